// File: rtl/sum_acc_pkg.sv
// ---------------------------------------------------------------------------
// sum_acc_pkg
//
// Shared definitions for the sum accumulator that sits directly after the top
// adder tree.
//
// Contents:
//   acc_state_e : state encoding for the accumulate / hold controller
//   clog2       : ceiling log2 used to size the result and count fields
// ---------------------------------------------------------------------------
package sum_acc_pkg;

    // ACCUM collects samples; HOLD presents a finished block until taken.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // Ceiling log2 for elaboration-time sizing. Returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >>> 1;
        end
        return result;
    endfunction

endpackage : sum_acc_pkg

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Adds up blocks of N unsigned samples coming out of the top adder tree and
// presents each block sum with a valid/ready handshake. A block normally
// closes when its Nth sample is accepted; flush closes a non-empty block
// early. The result appears one cycle after the closing sample and is held
// stable until the downstream consumer takes it.
//
// Parameters:
//   W  : input sample width
//   N  : samples per block (N >= 2)
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   sample present on in_data
//   in_data    in   [W-1:0] unsigned sample
//   in_ready   out  a sample is accepted this cycle when in_valid is also 1
//   flush      in   close the current block early
//   out_valid  out  out_data / out_count hold a completed result
//   out_data   out  [W+clog2(N)-1:0] block sum
//   out_count  out  [clog2(N):0] samples contained in out_data
//   out_ready  in   downstream takes the result this cycle
// ---------------------------------------------------------------------------
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int W = 6,
    parameter int N = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [W-1:0]            in_data,
    output logic                    in_ready,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [W+clog2(N)-1:0]   out_data,
    output logic [clog2(N):0]       out_count,
    input  logic                    out_ready
);

    // N*(2^W-1) fits in W+clog2(N) bits, so the running sum can never wrap.
    localparam int ACC_W = W + clog2(N);
    // One extra bit over clog2(N) so the count can reach N itself.
    localparam int CNT_W = clog2(N) + 1;

    localparam logic [CNT_W-1:0] BLOCK_LEN = CNT_W'(N);

    acc_state_e         state_q;
    acc_state_e         state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [ACC_W-1:0]   out_data_q;
    logic [ACC_W-1:0]   out_data_d;
    logic [CNT_W-1:0]   out_count_q;
    logic [CNT_W-1:0]   out_count_d;

    logic               accept;
    logic [ACC_W-1:0]   sum_next;
    logic [CNT_W-1:0]   count_next;
    logic               close_block;

    // The state register is already forced to ACCUM while reset is held, so
    // reset only needs to gate the ready output itself; acceptance is derived
    // from state alone to keep rst_n out of the flop data paths.
    assign accept    = in_valid && (state_q == ACCUM);
    assign in_ready  = rst_n && (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    // Running totals including any sample accepted this cycle.
    assign sum_next   = acc_q + (accept ? ACC_W'(in_data) : '0);
    assign count_next = count_q + CNT_W'(accept);

    // A block closes on its Nth sample, or on flush once it holds at least
    // one sample (counting a sample that arrives alongside the flush).
    assign close_block = (count_next == BLOCK_LEN) ||
                         (flush && (count_next != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    // On closing, the result moves to the output registers and the running
    // totals clear at once, so returning from HOLD needs no extra clearing.
    // In HOLD, in_valid and flush have no influence at all.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        unique case (state_q)
            ACCUM: begin
                if (close_block) begin
                    state_d     = HOLD;
                    out_data_d  = sum_next;
                    out_count_d = count_next;
                    acc_d       = '0;
                    count_d     = '0;
                end else begin
                    acc_d   = sum_next;
                    count_d = count_next;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

endmodule : sum_accumulator

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
//
// Self-checking bench for sum_accumulator (W=6, N=4). Directed scenarios and a
// randomized run are compared each cycle against a block-level reference
// model: a queue of the samples accepted in the current block and a pending
// result waiting for the consumer.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

    localparam int W     = 6;
    localparam int N     = 4;
    localparam int ACC_W = 8;
    localparam int CNT_W = 3;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic [W-1:0]       in_data;
    logic               in_ready;
    logic               flush;
    logic               out_valid;
    logic [ACC_W-1:0]   out_data;
    logic [CNT_W-1:0]   out_count;
    logic               out_ready;

    int passCount;
    int checkCount;

    // Reference model state
    int unsigned blockQ[$];
    bit          pending;
    int unsigned expSum;
    int unsigned expCount;

    sum_accumulator #(
        .W(W),
        .N(N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ready (out_ready)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison; observed values are zero-extended so X/Z survive.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Compare DUT outputs against what the model says is visible right now.
    task automatic checkVisible(input string tag);
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(!pending));
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(pending));
        if (pending) begin
            checkOutput({tag, ".out_data"}, 32'(out_data), expSum);
            checkOutput({tag, ".out_count"}, 32'(out_count), expCount);
        end
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic modelCycle(input bit v, input int unsigned d, input bit f, input bit r);
        int unsigned total;
        if (pending) begin
            if (r) pending = 0;
        end else begin
            if (v) blockQ.push_back(d);
            if (blockQ.size() == N || (f && blockQ.size() > 0)) begin
                total = 0;
                foreach (blockQ[i]) total += blockQ[i];
                expSum   = total;
                expCount = blockQ.size();
                pending  = 1;
                blockQ.delete();
            end
        end
    endtask

    // Called just after a falling edge: drive inputs, check, step the model,
    // then move to the next falling edge.
    task automatic applyStimulus(input string tag, input bit v, input int unsigned d,
                                 input bit f, input bit r);
        in_valid  = v;
        in_data   = W'(d);
        flush     = f;
        out_ready = r;
        #1;
        checkVisible(tag);
        modelCycle(v, d, f, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycles(input string tag, input int count, input bit r);
        for (int i = 0; i < count; i++) applyStimulus(tag, 1'b0, 0, 1'b0, r);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic resetPulse(input string tag);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput({tag, ".rst_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, ".rst_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".rst_out_data"}, 32'(out_data), 32'd0);
        checkOutput({tag, ".rst_out_count"}, 32'(out_count), 32'd0);
        #1 rst_n = 1'b1;
        blockQ.delete();
        pending = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int unsigned seq4[4];
        passCount  = 0;
        checkCount = 0;
        pending    = 0;
        expSum     = 0;
        expCount   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;

        // Reset state while rst_n is held low
        #12;
        checkOutput("reset.in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.out_data", 32'(out_data), 32'd0);
        checkOutput("reset.out_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic block: 10+20+30+40 = 100, valid for exactly one cycle
        seq4 = '{10, 20, 30, 40};
        foreach (seq4[i]) applyStimulus("basic", 1'b1, seq4[i], 1'b0, 1'b1);
        checkOutput("basic.sum100", 32'(out_data), 32'd100);
        idleCycles("basic_idle", 3, 1'b1);

        // Maximum values: 4*63 = 252 without wrap
        for (int i = 0; i < 4; i++) applyStimulus("max", 1'b1, 63, 1'b0, 1'b1);
        checkOutput("max.sum252", 32'(out_data), 32'd252);
        idleCycles("max_idle", 2, 1'b1);

        // Backpressure: result held, input and flush ignored while holding
        foreach (seq4[i]) applyStimulus("bp_fill", 1'b1, seq4[i], 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus("bp_hold", 1'b1, 7, 1'b1, 1'b0);
        applyStimulus("bp_release", 1'b0, 0, 1'b0, 1'b1);
        idleCycles("bp_idle", 2, 1'b1);

        // Flush with a sample in the same cycle: 5+7 = 12, count 2
        applyStimulus("flush_a", 1'b1, 5, 1'b0, 1'b1);
        applyStimulus("flush_b", 1'b1, 7, 1'b1, 1'b1);
        checkOutput("flush.sum12", 32'(out_data), 32'd12);
        checkOutput("flush.count2", 32'(out_count), 32'd2);
        idleCycles("flush_idle", 1, 1'b1);
        // Flush with nothing collected produces no result
        applyStimulus("flush_empty", 1'b0, 0, 1'b1, 1'b1);
        idleCycles("flush_empty_idle", 2, 1'b1);

        // Gapped input: 1,2,3,4 with two idle cycles between samples
        for (int i = 1; i <= 4; i++) begin
            applyStimulus("gap", 1'b1, i, 1'b0, 1'b1);
            if (i < 4) idleCycles("gap_idle", 2, 1'b1);
        end
        checkOutput("gap.sum10", 32'(out_data), 32'd10);
        idleCycles("gap_tail", 2, 1'b1);

        // Reset mid-block discards 9+9; following block sums to 4
        applyStimulus("rst_mid", 1'b1, 9, 1'b0, 1'b1);
        applyStimulus("rst_mid", 1'b1, 9, 1'b0, 1'b1);
        resetPulse("rst_mid");
        for (int i = 0; i < 4; i++) applyStimulus("rst_after", 1'b1, 1, 1'b0, 1'b1);
        checkOutput("rst_after.sum4", 32'(out_data), 32'd4);
        idleCycles("rst_after_idle", 2, 1'b1);

        // Reset while holding a result discards it
        foreach (seq4[i]) applyStimulus("rst_hold_fill", 1'b1, seq4[i], 1'b0, 1'b0);
        applyStimulus("rst_hold", 1'b0, 0, 1'b0, 1'b0);
        resetPulse("rst_hold");
        idleCycles("rst_hold_idle", 2, 1'b1);

        // Randomized traffic with random flush and backpressure
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 9) < 7),
                          $urandom_range(0, 63),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 9) < 6));
        end
        idleCycles("rand_drain", 3, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_sum_accumulator
